wakeup_ctrl: RTL and testbench

Parametrised wakeup and operand-ready tracker for one issue queue. It holds a registered ready bit per source operand per entry and delays each granted destination tag by its unit latency before broadcasting it. Ready bits are set by tag match, gated by broadcast valids, with a same-cycle bypass for back-to-back issue. Sits between the select/grant logic and the issue-queue payload RAM.

---
 rtl/wakeup_pkg.sv | 34 +++
 rtl/wb_delay_line.sv | 59 +++++
 rtl/wakeup_ctrl.sv | 95 +++++++++
 tb/tb_wakeup_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wakeup_pkg.sv
// Shared widths, the broadcast slot type and small helpers for the
// issue-queue wakeup tracker.
package wakeup_pkg;

   localparam int PRF_WIDTH = 6;
   localparam int IQ_DEPTH  = 16;
   localparam int NUM_WB    = 4;
   localparam int MAX_LAT   = 4;
   localparam int IDX_W     = $clog2(IQ_DEPTH);
   localparam int LAT_W     = $clog2(MAX_LAT + 1);

   typedef struct packed {
      logic                 vld;
      logic [PRF_WIDTH-1:0] tag;
   } bcast_slot_t;

   // Out-of-range latencies (0 or above MAX_LAT) fall back to the slowest slot.
   function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] lat);
      if (lat == '0 || lat > LAT_W'(MAX_LAT)) return LAT_W'(MAX_LAT);
      return lat;
   endfunction

   function automatic logic tag_match(input logic [PRF_WIDTH-1:0]             tag,
                                      input logic [NUM_WB-1:0]                vld,
                                      input logic [NUM_WB-1:0][PRF_WIDTH-1:0] tags);
      logic hit;
      hit = 1'b0;
      for (int c = 0; c < NUM_WB; c++) begin
         if (vld[c] && tags[c] == tag) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/wb_delay_line.sv
// Per-channel latency delay line: a grant is parked in slot L-1 and walks
// down one slot per cycle until it is broadcast from slot 0.
module wb_delay_line
   import wakeup_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 grant_vld,
   input  logic [PRF_WIDTH-1:0] grant_prd,
   input  logic                 grant_wen,
   input  logic [LAT_W-1:0]     grant_lat,
   output bcast_slot_t          head,
   output logic                 conflict
);

   bcast_slot_t      stage_q [MAX_LAT];
   bcast_slot_t      stage_d [MAX_LAT];
   bcast_slot_t      shifted [MAX_LAT];
   logic             ins;
   logic             conflict_d;
   logic [LAT_W-1:0] slot;

   always_comb begin
      for (int k = 0; k < MAX_LAT - 1; k++) shifted[k] = stage_q[k+1];
      shifted[MAX_LAT-1] = '0;

      ins        = grant_vld & grant_wen & (grant_prd != '0) & ~flush;
      slot       = eff_lat(grant_lat) - LAT_W'(1);
      conflict_d = 1'b0;

      for (int k = 0; k < MAX_LAT; k++) stage_d[k] = shifted[k];

      // The older wakeup already owns the slot; the new grant is lost.
      for (int k = 0; k < MAX_LAT; k++) begin
         if (ins && slot == LAT_W'(k)) begin
            if (shifted[k].vld) conflict_d = 1'b1;
            else                stage_d[k] = '{vld: 1'b1, tag: grant_prd};
         end
      end

      if (flush) begin
         for (int k = 0; k < MAX_LAT; k++) stage_d[k] = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < MAX_LAT; k++) stage_q[k] <= '0;
         conflict <= 1'b0;
      end else begin
         for (int k = 0; k < MAX_LAT; k++) stage_q[k] <= stage_d[k];
         conflict <= conflict_d;
      end
   end

   assign head = stage_q[0];

endmodule

// File: rtl/wakeup_ctrl.sv
// Operand-ready tracker for one issue queue: per-entry ready bits woken by
// delayed destination-tag broadcasts, with a same-cycle bypass.
module wakeup_ctrl
   import wakeup_pkg::*;
(
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic                                alloc_vld,
   input  logic [IDX_W-1:0]                    alloc_idx,
   input  logic [PRF_WIDTH-1:0]                alloc_prs1,
   input  logic [PRF_WIDTH-1:0]                alloc_prs2,
   input  logic                                alloc_rdy1,
   input  logic                                alloc_rdy2,
   input  logic [IQ_DEPTH-1:0]                 dealloc_vld,
   input  logic [NUM_WB-1:0]                   grant_vld,
   input  logic [NUM_WB-1:0][PRF_WIDTH-1:0]    grant_prd,
   input  logic [NUM_WB-1:0]                   grant_wen,
   input  logic [NUM_WB-1:0][LAT_W-1:0]        grant_lat,
   output logic [NUM_WB-1:0]                   bus_vld,
   output logic [NUM_WB-1:0][PRF_WIDTH-1:0]    bus_tag,
   output logic [IQ_DEPTH-1:0]                 prs1_rdy,
   output logic [IQ_DEPTH-1:0]                 prs2_rdy,
   output logic [IQ_DEPTH-1:0]                 entry_rdy,
   output logic [NUM_WB-1:0]                   wb_conflict
);

   bcast_slot_t head [NUM_WB];

   for (genvar c = 0; c < NUM_WB; c++) begin : g_ch
      wb_delay_line u_delay (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .grant_vld (grant_vld[c]),
         .grant_prd (grant_prd[c]),
         .grant_wen (grant_wen[c]),
         .grant_lat (grant_lat[c]),
         .head      (head[c]),
         .conflict  (wb_conflict[c])
      );
      assign bus_vld[c] = head[c].vld;
      assign bus_tag[c] = head[c].tag;
   end

   logic [IQ_DEPTH-1:0]  valid_q;
   logic [IQ_DEPTH-1:0]  rdy1_q;
   logic [IQ_DEPTH-1:0]  rdy2_q;
   logic [PRF_WIDTH-1:0] prs1_q [IQ_DEPTH];
   logic [PRF_WIDTH-1:0] prs2_q [IQ_DEPTH];
   logic [IQ_DEPTH-1:0]  match1;
   logic [IQ_DEPTH-1:0]  match2;
   logic                 alloc_r1;
   logic                 alloc_r2;

   always_comb begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
         match1[i] = tag_match(prs1_q[i], bus_vld, bus_tag);
         match2[i] = tag_match(prs2_q[i], bus_vld, bus_tag);
      end
      prs1_rdy  = rdy1_q | match1;
      prs2_rdy  = rdy2_q | match2;
      entry_rdy = valid_q & prs1_rdy & prs2_rdy;
      // A new entry also catches a wakeup that is on the bus this very cycle.
      alloc_r1  = alloc_rdy1 | (alloc_prs1 == '0) | tag_match(alloc_prs1, bus_vld, bus_tag);
      alloc_r2  = alloc_rdy2 | (alloc_prs2 == '0) | tag_match(alloc_prs2, bus_vld, bus_tag);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         rdy1_q  <= '0;
         rdy2_q  <= '0;
         for (int i = 0; i < IQ_DEPTH; i++) begin
            prs1_q[i] <= '0;
            prs2_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < IQ_DEPTH; i++) begin
            rdy1_q[i] <= rdy1_q[i] | match1[i];
            rdy2_q[i] <= rdy2_q[i] | match2[i];
            if (dealloc_vld[i]) valid_q[i] <= 1'b0;
            if (alloc_vld && alloc_idx == IDX_W'(i)) begin
               valid_q[i] <= 1'b1;
               prs1_q[i]  <= alloc_prs1;
               prs2_q[i]  <= alloc_prs2;
               rdy1_q[i]  <= alloc_r1;
               rdy2_q[i]  <= alloc_r2;
            end
            if (flush) valid_q[i] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wakeup_ctrl.sv
// Self-checking bench for wakeup_ctrl: directed scenarios plus a randomized
// grant/broadcast scoreboard.
module tb_wakeup_ctrl;
   import wakeup_pkg::*;

   logic                             clk;
   logic                             rst;
   logic                             flush;
   logic                             alloc_vld;
   logic [IDX_W-1:0]                 alloc_idx;
   logic [PRF_WIDTH-1:0]             alloc_prs1;
   logic [PRF_WIDTH-1:0]             alloc_prs2;
   logic                             alloc_rdy1;
   logic                             alloc_rdy2;
   logic [IQ_DEPTH-1:0]              dealloc_vld;
   logic [NUM_WB-1:0]                grant_vld;
   logic [NUM_WB-1:0][PRF_WIDTH-1:0] grant_prd;
   logic [NUM_WB-1:0]                grant_wen;
   logic [NUM_WB-1:0][LAT_W-1:0]     grant_lat;
   logic [NUM_WB-1:0]                bus_vld;
   logic [NUM_WB-1:0][PRF_WIDTH-1:0] bus_tag;
   logic [IQ_DEPTH-1:0]              prs1_rdy;
   logic [IQ_DEPTH-1:0]              prs2_rdy;
   logic [IQ_DEPTH-1:0]              entry_rdy;
   logic [NUM_WB-1:0]                wb_conflict;

   int total;
   int bad;
   logic [PRF_WIDTH-1:0] exp_q[$];
   logic [LAT_W-1:0]     exp_lat_q[$];

   wakeup_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .alloc_vld   (alloc_vld),
      .alloc_idx   (alloc_idx),
      .alloc_prs1  (alloc_prs1),
      .alloc_prs2  (alloc_prs2),
      .alloc_rdy1  (alloc_rdy1),
      .alloc_rdy2  (alloc_rdy2),
      .dealloc_vld (dealloc_vld),
      .grant_vld   (grant_vld),
      .grant_prd   (grant_prd),
      .grant_wen   (grant_wen),
      .grant_lat   (grant_lat),
      .bus_vld     (bus_vld),
      .bus_tag     (bus_tag),
      .prs1_rdy    (prs1_rdy),
      .prs2_rdy    (prs2_rdy),
      .entry_rdy   (entry_rdy),
      .wb_conflict (wb_conflict)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic clear_inputs();
      flush       = 1'b0;
      alloc_vld   = 1'b0;
      alloc_idx   = '0;
      alloc_prs1  = '0;
      alloc_prs2  = '0;
      alloc_rdy1  = 1'b0;
      alloc_rdy2  = 1'b0;
      dealloc_vld = '0;
      grant_vld   = '0;
      grant_prd   = '0;
      grant_wen   = '0;
      grant_lat   = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic drive_alloc(input int idx, input int p1, input int p2, input bit r1, input bit r2);
      alloc_vld  = 1'b1;
      alloc_idx  = IDX_W'(idx);
      alloc_prs1 = PRF_WIDTH'(p1);
      alloc_prs2 = PRF_WIDTH'(p2);
      alloc_rdy1 = r1;
      alloc_rdy2 = r2;
   endtask

   task automatic drive_grant(input int c, input int prd, input bit wen, input int lat);
      grant_vld[c] = 1'b1;
      grant_prd[c] = PRF_WIDTH'(prd);
      grant_wen[c] = wen;
      grant_lat[c] = LAT_W'(lat);
   endtask

   // scenarios
   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if (bus_vld !== '0 || bus_tag !== '0 || wb_conflict !== '0) begin
         bad++;
         $display("FAIL reset_bus: bus_vld=%b bus_tag=%h conflict=%b want all 0", bus_vld, bus_tag, wb_conflict);
      end
      total++;
      if (prs1_rdy !== '0 || prs2_rdy !== '0 || entry_rdy !== '0) begin
         bad++;
         $display("FAIL reset_rdy: prs1=%h prs2=%h entry=%h want 0", prs1_rdy, prs2_rdy, entry_rdy);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      step();
      drive_alloc(3, 5, 0, 1'b0, 1'b0);
      step();
      drive_grant(0, 5, 1'b1, 1);
      @(negedge clk);
      total++;
      if (entry_rdy[3] !== 1'b0 || prs2_rdy[3] !== 1'b1) begin
         bad++;
         $display("FAIL b2b_wait: entry_rdy3=%b prs2_rdy3=%b want 0 1", entry_rdy[3], prs2_rdy[3]);
      end
      step();
      @(negedge clk);
      total++;
      if (bus_vld !== 4'b0001 || bus_tag[0] !== 6'd5 || entry_rdy[3] !== 1'b1) begin
         bad++;
         $display("FAIL b2b_wake: bus_vld=%b tag0=%0d entry_rdy3=%b want 0001 5 1", bus_vld, bus_tag[0], entry_rdy[3]);
      end
      step();
      @(negedge clk);
      total++;
      if (bus_vld !== '0 || prs1_rdy[3] !== 1'b1 || entry_rdy[3] !== 1'b1) begin
         bad++;
         $display("FAIL b2b_hold: bus_vld=%b prs1_rdy3=%b entry_rdy3=%b want 0 1 1", bus_vld, prs1_rdy[3], entry_rdy[3]);
      end
   endtask

   task automatic test_lat3();
      step();
      drive_alloc(7, 9, 9, 1'b0, 1'b0);
      step();
      drive_grant(2, 9, 1'b1, 3);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (bus_vld !== '0 || entry_rdy[7] !== 1'b0) begin
            bad++;
            $display("FAIL lat3_early: cyc=%0d bus_vld=%b entry_rdy7=%b want 0 0", k, bus_vld, entry_rdy[7]);
         end
         step();
      end
      @(negedge clk);
      total++;
      if (bus_vld !== 4'b0100 || bus_tag[2] !== 6'd9 || entry_rdy[7] !== 1'b1) begin
         bad++;
         $display("FAIL lat3_wake: bus_vld=%b tag2=%0d entry_rdy7=%b want 0100 9 1", bus_vld, bus_tag[2], entry_rdy[7]);
      end
   endtask

   task automatic test_conflict();
      step();
      drive_grant(2, 9, 1'b1, 3);
      step();
      drive_grant(2, 10, 1'b1, 2);
      @(negedge clk);
      total++;
      if (wb_conflict !== '0) begin
         bad++;
         $display("FAIL conf_early: wb_conflict=%b want 0000", wb_conflict);
      end
      step();
      @(negedge clk);
      total++;
      if (wb_conflict !== 4'b0100 || bus_vld !== '0) begin
         bad++;
         $display("FAIL conf_pulse: wb_conflict=%b bus_vld=%b want 0100 0000", wb_conflict, bus_vld);
      end
      step();
      @(negedge clk);
      total++;
      if (bus_vld !== 4'b0100 || bus_tag[2] !== 6'd9 || wb_conflict !== '0) begin
         bad++;
         $display("FAIL conf_keep_old: bus_vld=%b tag2=%0d conflict=%b want 0100 9 0000", bus_vld, bus_tag[2], wb_conflict);
      end
      step();
      @(negedge clk);
      total++;
      if (bus_vld !== '0) begin
         bad++;
         $display("FAIL conf_dropped: bus_vld=%b want 0000", bus_vld);
      end
   endtask

   task automatic test_alloc_bypass();
      step();
      drive_grant(1, 12, 1'b1, 1);
      step();
      drive_alloc(4, 12, 0, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (bus_vld !== 4'b0010 || bus_tag[1] !== 6'd12) begin
         bad++;
         $display("FAIL abyp_bus: bus_vld=%b tag1=%0d want 0010 12", bus_vld, bus_tag[1]);
      end
      step();
      @(negedge clk);
      total++;
      if (entry_rdy[4] !== 1'b1 || prs1_rdy[4] !== 1'b1 || bus_vld !== '0) begin
         bad++;
         $display("FAIL abyp_rdy: entry_rdy4=%b prs1_rdy4=%b bus_vld=%b want 1 1 0", entry_rdy[4], prs1_rdy[4], bus_vld);
      end
      dealloc_vld[4] = 1'b1;
      step();
      @(negedge clk);
      total++;
      if (entry_rdy[4] !== 1'b0) begin
         bad++;
         $display("FAIL dealloc: entry_rdy4=%b want 0", entry_rdy[4]);
      end
      drive_alloc(4, 0, 0, 1'b0, 1'b0);
      dealloc_vld[4] = 1'b1;
      step();
      @(negedge clk);
      total++;
      if (entry_rdy[4] !== 1'b1) begin
         bad++;
         $display("FAIL alloc_over_dealloc: entry_rdy4=%b want 1", entry_rdy[4]);
      end
   endtask

   task automatic test_no_bcast();
      step();
      drive_grant(3, 20, 1'b0, 1);
      drive_grant(0, 0, 1'b1, 1);
      drive_grant(1, 21, 1'b1, 0);
      drive_grant(2, 22, 1'b1, 7);
      for (int k = 1; k <= 3; k++) begin
         step();
         @(negedge clk);
         total++;
         if (bus_vld !== '0) begin
            bad++;
            $display("FAIL nobc_quiet: cyc=%0d bus_vld=%b want 0000", k, bus_vld);
         end
      end
      step();
      @(negedge clk);
      total++;
      if (bus_vld !== 4'b0110 || bus_tag[1] !== 6'd21 || bus_tag[2] !== 6'd22) begin
         bad++;
         $display("FAIL lat_clamp: bus_vld=%b tag1=%0d tag2=%0d want 0110 21 22", bus_vld, bus_tag[1], bus_tag[2]);
      end
   endtask

   task automatic test_flush();
      step();
      drive_alloc(8, 30, 30, 1'b0, 1'b0);
      drive_grant(0, 30, 1'b1, 2);
      step();
      flush = 1'b1;
      drive_grant(1, 31, 1'b1, 1);
      for (int k = 2; k <= 4; k++) begin
         step();
         @(negedge clk);
         total++;
         if (bus_vld !== '0 || entry_rdy !== '0) begin
            bad++;
            $display("FAIL flush: cyc=t+%0d bus_vld=%b entry_rdy=%h want 0 0", k, bus_vld, entry_rdy);
         end
      end
   endtask

   task automatic test_random_grants();
      for (int n = 0; n < 24; n++) begin
         int c;
         int idx;
         logic [PRF_WIDTH-1:0] tag;
         logic [LAT_W-1:0] lat;
         bit found;
         c   = $urandom_range(0, NUM_WB - 1);
         idx = $urandom_range(9, 15);
         tag = PRF_WIDTH'($urandom_range(1, 63));
         lat = LAT_W'($urandom_range(1, MAX_LAT));
         step();
         drive_grant(c, int'(tag), 1'b1, int'(lat));
         drive_alloc(idx, int'(tag), 0, 1'b0, 1'b0);
         exp_q.push_back(tag);
         exp_lat_q.push_back(lat);
         found = 1'b0;
         for (int k = 1; k <= MAX_LAT + 1 && !found; k++) begin
            step();
            @(negedge clk);
            if (bus_vld[c]) begin
               logic [PRF_WIDTH-1:0] et;
               logic [LAT_W-1:0] el;
               found = 1'b1;
               et = exp_q.pop_front();
               el = exp_lat_q.pop_front();
               total++;
               if (bus_tag[c] !== et || k != int'(el) || entry_rdy[idx] !== 1'b1) begin
                  bad++;
                  $display("FAIL rnd_bcast: ch=%0d tag=%0d lat=%0d entry_rdy=%b want tag=%0d lat=%0d rdy=1",
                           c, bus_tag[c], k, entry_rdy[idx], et, el);
               end
            end else begin
               total++;
               if (bus_vld !== '0 || entry_rdy[idx] !== 1'b0) begin
                  bad++;
                  $display("FAIL rnd_early: ch=%0d cyc=%0d bus_vld=%b entry_rdy=%b want 0 0", c, k, bus_vld, entry_rdy[idx]);
               end
            end
         end
         if (!found) begin
            total++;
            bad++;
            $display("FAIL rnd_timeout: ch=%0d no broadcast of tag %0d within %0d cycles", c, tag, MAX_LAT + 1);
            void'(exp_q.pop_front());
            void'(exp_lat_q.pop_front());
         end
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 10; i++) begin
         step();
         drive_alloc(i, 40 + i, 0, 1'b1, 1'b1);
      end
      step();
      drive_grant(0, 50, 1'b1, 3);
      drive_grant(1, 51, 1'b1, 4);
      drive_grant(3, 52, 1'b1, 4);
      @(negedge clk);
      total++;
      if (entry_rdy[9:0] !== 10'h3ff) begin
         bad++;
         $display("FAIL mrst_pre: entry_rdy[9:0]=%h want 3ff", entry_rdy[9:0]);
      end
      step();
      rst = 1'b1;
      #1;
      total++;
      if (bus_vld !== '0 || entry_rdy !== '0 || prs1_rdy !== '0 || prs2_rdy !== '0 || wb_conflict !== '0) begin
         bad++;
         $display("FAIL mrst_now: bus=%b entry=%h p1=%h p2=%h conf=%b want 0", bus_vld, entry_rdy, prs1_rdy, prs2_rdy, wb_conflict);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         total++;
         if (bus_vld !== '0 || bus_tag !== '0 || entry_rdy !== '0 || prs1_rdy !== '0 || prs2_rdy !== '0) begin
            bad++;
            $display("FAIL mrst_after: cyc=%0d bus=%b tag=%h entry=%h p1=%h p2=%h want 0", k, bus_vld, bus_tag, entry_rdy, prs1_rdy, prs2_rdy);
         end
         step();
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_back_to_back();
      test_lat3();
      test_conflict();
      test_alloc_bypass();
      test_no_bcast();
      test_flush();
      test_random_grants();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
